// File: rtl/toggle_period_rx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | toggle_period_rx_if                                                  |
// | Raw blink input and measurement outputs of toggle_period_rx.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface toggle_period_rx_if #(
   parameter int CNT_W = 27
);
   logic             din;
   logic             level;
   logic             edge_pulse;
   logic [CNT_W-1:0] half_period;
   logic             period_valid;
   logic             locked;
   logic             timeout;

   modport master (
      output din,
      input  level, edge_pulse, half_period, period_valid, locked, timeout
   );

   modport slave (
      input  din,
      output level, edge_pulse, half_period, period_valid, locked, timeout
   );
endinterface
`default_nettype wire

// File: rtl/toggle_period_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | toggle_period_rx                                                     |
// | Debounces a blinking input, measures half-periods, tracks lock.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module toggle_period_rx #(
   parameter int CLK_FREQ        = 50_000_000,
   parameter int CNT_W           = 27,
   parameter int DEBOUNCE_CYCLES = CLK_FREQ / 50_000,
   parameter int TIMEOUT_CYCLES  = 2 * CLK_FREQ,
   parameter int TOL             = CLK_FREQ / 100,
   parameter int LOCK_COUNT      = 4
) (
   input  logic              clk,
   input  logic              rst,
   toggle_period_rx_if.slave bus
);
   localparam int c_deb_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int c_mat_w = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
   localparam logic [c_deb_w-1:0] c_deb_last = c_deb_w'(DEBOUNCE_CYCLES - 1);
   localparam logic [c_mat_w-1:0] c_mat_last = c_mat_w'(LOCK_COUNT - 1);
   localparam logic [CNT_W-1:0]   c_cnt_max  = '1;
   localparam logic [CNT_W-1:0]   c_timeout  = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W:0]     c_tol      = (CNT_W + 1)'(TOL);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FIRST  = 2'd1,
      S_TRACK  = 2'd2,
      S_LOCKED = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic               sync1_q, sync1_d, sync2_q, sync2_d;
   logic               level_q, level_d, edge_q, edge_d;
   logic [c_deb_w-1:0] deb_q, deb_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d, half_q, half_d;
   logic               pv_q, pv_d, locked_q, locked_d;
   logic [c_mat_w-1:0] match_q, match_d;

   logic [CNT_W:0]     w_diff;
   logic               w_match;
   logic               w_timeout;

   assign w_diff    = (cnt_q >= half_q) ? ({1'b0, cnt_q} - {1'b0, half_q})
                                        : ({1'b0, half_q} - {1'b0, cnt_q});
   assign w_match   = (w_diff <= c_tol);
   // An accepted edge in the same cycle always beats the timeout.
   assign w_timeout = (state_q != S_IDLE) && (cnt_q == c_timeout) && !edge_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         level_q  <= 1'b0;
         edge_q   <= 1'b0;
         deb_q    <= '0;
         cnt_q    <= '0;
         half_q   <= '0;
         pv_q     <= 1'b0;
         locked_q <= 1'b0;
         match_q  <= '0;
      end else begin
         state_q  <= state_d;
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         level_q  <= level_d;
         edge_q   <= edge_d;
         deb_q    <= deb_d;
         cnt_q    <= cnt_d;
         half_q   <= half_d;
         pv_q     <= pv_d;
         locked_q <= locked_d;
         match_q  <= match_d;
      end
   end

   always_comb begin
      sync1_d  = bus.din;
      sync2_d  = sync1_q;
      level_d  = level_q;
      edge_d   = 1'b0;
      deb_d    = '0;
      state_d  = state_q;
      cnt_d    = cnt_q;
      half_d   = half_q;
      pv_d     = 1'b0;
      locked_d = locked_q;
      match_d  = match_q;

      if (sync2_q != level_q) begin
         if (deb_q == c_deb_last) begin
            level_d = ~level_q;
            edge_d  = 1'b1;
         end else begin
            deb_d = deb_q + 1'b1;
         end
      end

      if (edge_q) begin
         cnt_d = CNT_W'(1);
         case (state_q)
            S_IDLE: state_d = S_FIRST;
            S_FIRST: begin
               half_d  = cnt_q;
               pv_d    = 1'b1;
               match_d = '0;
               state_d = S_TRACK;
            end
            S_TRACK: begin
               half_d = cnt_q;
               pv_d   = 1'b1;
               if (!w_match) begin
                  match_d = '0;
               end else if (match_q == c_mat_last) begin
                  locked_d = 1'b1;
                  state_d  = S_LOCKED;
               end else begin
                  match_d = match_q + 1'b1;
               end
            end
            S_LOCKED: begin
               half_d = cnt_q;
               pv_d   = 1'b1;
               if (!w_match) begin
                  locked_d = 1'b0;
                  match_d  = '0;
                  state_d  = S_TRACK;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end else if (w_timeout) begin
         cnt_d    = '0;
         locked_d = 1'b0;
         match_d  = '0;
         state_d  = S_IDLE;
      end else if ((state_q != S_IDLE) && (cnt_q != c_cnt_max)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign bus.level        = level_q;
   assign bus.edge_pulse   = edge_q;
   assign bus.half_period  = half_q;
   assign bus.period_valid = pv_q;
   assign bus.locked       = locked_q;
   assign bus.timeout      = w_timeout;

endmodule
`default_nettype wire
